// File: rtl/module_control_muestreo_if.sv
// ---------------------------------------------------------------------------
// module_control_muestreo_if
//
// Handshake between the sampling controller and the binary-to-BCD converter.
//
// Signals:
//   conv_start_o  one-cycle start pulse towards the converter
//   conv_bin_o    4-bit operand, held stable while a conversion runs
//   conv_done_i   converter result-ready pulse
//   bcd_i         converter result, tens [7:4], units [3:0]
//
// Modports:
//   master  the sampling controller (drives start/operand)
//   slave   the converter (drives done/result)
// ---------------------------------------------------------------------------
interface module_control_muestreo_if;
    logic       conv_start_o;
    logic [3:0] conv_bin_o;
    logic       conv_done_i;
    logic [7:0] bcd_i;

    modport master (
        output conv_start_o,
        output conv_bin_o,
        input  conv_done_i,
        input  bcd_i
    );

    modport slave (
        input  conv_start_o,
        input  conv_bin_o,
        output conv_done_i,
        output bcd_i
    );
endinterface

// File: rtl/module_control_muestreo.sv
// ---------------------------------------------------------------------------
// module_control_muestreo
//
// Periodically samples a 4-bit code, sends it to an external bin-to-BCD
// converter only when it changed (or nothing has been shown yet), and
// multiplexes the two resulting BCD digits onto a 2-digit display.
//
// Parameters:
//   INPUT_REFRESH    clk cycles between input samples
//   DISPLAY_REFRESH  clk cycles each digit slot stays active
//   TIMEOUT          max clk cycles to wait for conv_done_i
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-low reset
//   codigo_bin_i   decoded binary value from the reader
//   conv           converter handshake (master side)
//   digito_o       BCD nibble of the active slot
//   anodo_o        active-low digit enables, [0] units, [1] tens
//   dato_valido_o  high once a first conversion has been displayed
//   error_o        sticky converter-timeout flag
// ---------------------------------------------------------------------------
module module_control_muestreo #(
    parameter int INPUT_REFRESH   = 2700000,
    parameter int DISPLAY_REFRESH = 27000,
    parameter int TIMEOUT         = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [3:0]                        codigo_bin_i,
    module_control_muestreo_if.master         conv,
    output logic [3:0]                        digito_o,
    output logic [1:0]                        anodo_o,
    output logic                              dato_valido_o,
    output logic                              error_o
);

    localparam int SAMPLE_W = (INPUT_REFRESH   > 1) ? $clog2(INPUT_REFRESH)   : 1;
    localparam int DISP_W   = (DISPLAY_REFRESH > 1) ? $clog2(DISPLAY_REFRESH) : 1;
    localparam int TO_W     = (TIMEOUT         > 1) ? $clog2(TIMEOUT)         : 1;

    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(INPUT_REFRESH - 1);
    localparam logic [DISP_W-1:0]   DISP_LAST   = DISP_W'(DISPLAY_REFRESH - 1);
    localparam logic [TO_W-1:0]     TO_LAST     = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUESTREO,
        CONVIRTIENDO,
        ACTUALIZAR
    } state_t;

    state_t              state_reg,      state_next;
    logic [SAMPLE_W-1:0] sample_cnt_reg, sample_cnt_next;
    logic [DISP_W-1:0]   disp_cnt_reg,   disp_cnt_next;
    logic [TO_W-1:0]     to_cnt_reg,     to_cnt_next;
    logic                slot_reg,       slot_next;      // 0 = units, 1 = tens
    logic                pending_reg,    pending_next;
    logic                start_reg,      start_next;
    logic [3:0]          bin_reg,        bin_next;
    logic [3:0]          last_bin_reg,   last_bin_next;  // operand of the shown value
    logic [7:0]          result_reg,     result_next;    // BCD captured on done
    logic [7:0]          display_reg,    display_next;
    logic                valid_reg,      valid_next;
    logic                error_reg,      error_next;

    logic sample_tick;
    logic disp_wrap;
    logic need_conv;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        sample_tick     = (sample_cnt_reg == SAMPLE_LAST);
        sample_cnt_next = sample_tick ? '0 : sample_cnt_reg + SAMPLE_W'(1);

        disp_wrap       = (disp_cnt_reg == DISP_LAST);
        disp_cnt_next   = disp_wrap ? '0 : disp_cnt_reg + DISP_W'(1);
        slot_next       = disp_wrap ? ~slot_reg : slot_reg;

        // A conversion is only worth starting if the reading changed or
        // nothing has ever been shown.
        need_conv       = (codigo_bin_i != last_bin_reg) || !valid_reg;

        state_next      = state_reg;
        to_cnt_next     = to_cnt_reg;
        start_next      = 1'b0;
        bin_next        = bin_reg;
        last_bin_next   = last_bin_reg;
        result_next     = result_reg;
        display_next    = display_reg;
        valid_next      = valid_reg;
        error_next      = error_reg;

        case (state_reg)
            IDLE: begin
                if (sample_tick || pending_reg) begin
                    state_next = MUESTREO;
                end
            end
            MUESTREO: begin
                bin_next = codigo_bin_i;
                if (need_conv) begin
                    start_next  = 1'b1;
                    to_cnt_next = '0;
                    state_next  = CONVIRTIENDO;
                end else begin
                    state_next  = IDLE;
                end
            end
            CONVIRTIENDO: begin
                // done wins over a timeout landing on the same cycle
                if (conv.conv_done_i) begin
                    result_next = conv.bcd_i;
                    state_next  = ACTUALIZAR;
                end else if (to_cnt_reg == TO_LAST) begin
                    error_next  = 1'b1;
                    state_next  = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
            end
            ACTUALIZAR: begin
                display_next  = result_reg;
                last_bin_next = bin_reg;
                valid_next    = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Only one tick can be remembered while busy; entering MUESTREO
        // consumes it.
        pending_next = pending_reg;
        if (state_reg == IDLE && state_next == MUESTREO) begin
            pending_next = 1'b0;
        end else if (sample_tick && state_reg != IDLE) begin
            pending_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            disp_cnt_reg   <= '0;
            to_cnt_reg     <= '0;
            slot_reg       <= 1'b0;
            pending_reg    <= 1'b0;
            start_reg      <= 1'b0;
            bin_reg        <= 4'd0;
            last_bin_reg   <= 4'd0;
            result_reg     <= 8'h00;
            display_reg    <= 8'h00;
            valid_reg      <= 1'b0;
            error_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            disp_cnt_reg   <= disp_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            slot_reg       <= slot_next;
            pending_reg    <= pending_next;
            start_reg      <= start_next;
            bin_reg        <= bin_next;
            last_bin_reg   <= last_bin_next;
            result_reg     <= result_next;
            display_reg    <= display_next;
            valid_reg      <= valid_next;
            error_reg      <= error_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign conv.conv_start_o = start_reg;
    assign conv.conv_bin_o   = bin_reg;
    assign dato_valido_o     = valid_reg;
    assign error_o           = error_reg;
    assign digito_o          = slot_reg ? display_reg[7:4] : display_reg[3:0];

    // One enable per digit: lit only in its own slot, once valid, and the
    // tens digit stays dark when it is a leading zero.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_anodo
            logic digit_on;
            assign digit_on = valid_reg
                            && (slot_reg == 1'(gi))
                            && ((gi == 0) || (display_reg[4*gi +: 4] != 4'd0));
            assign anodo_o[gi] = ~digit_on;
        end
    endgenerate

endmodule
